// File: rtl/subsample_8x8.sv
// subsample_8x8: 4:2:0 chroma downsampler for the encoder path.
// Each 16x16 chroma MCU arrives as four 8x8 blocks (TL, TR, BL, BR). Every
// 2x2 window is averaged with rounding into one quadrant of a single 8x8
// output block. Luma blocks pass straight through with the same latency.
// The channel tag is 2 bits wide, enough for three channels (Y, Cb, Cr).
module subsample_8x8 (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            ch,
  input  logic                  valid_in,
  input  logic [7:0][7:0][7:0]  block_in,
  output logic                  valid_out,
  output logic [7:0][7:0][7:0]  block_out,
  output logic [1:0]            ch_out
);

  localparam logic [1:0] CH_Y  = 2'b00;
  localparam logic [1:0] CH_CB = 2'b01;
  localparam logic [1:0] CH_CR = 2'b10;

  // State names give how many quadrants of the current group are staged.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    Q1    = 2'd1,
    Q2    = 2'd2,
    Q3    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             grpCh_q, grpCh_d;
  logic [7:0][7:0][7:0]   staging_q, staging_d;
  logic [7:0][7:0][7:0]   blockOut_q, blockOut_d;
  logic [1:0]             chOut_q, chOut_d;
  logic                   validOut_q, validOut_d;

  logic [3:0][3:0][7:0]   quadAvg;
  logic [7:0][7:0][7:0]   merged;
  logic                   isChroma;
  logic                   startNew;
  logic [1:0]             quadSel;

  // The 10-bit window sum cannot overflow (4*255+2 = 1022), and after the
  // shift the result is at most 255, so no saturation is needed.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic [9:0] windowSum;
      assign windowSum = {2'b00, block_in[2*r][2*c]}
                       + {2'b00, block_in[2*r][2*c+1]}
                       + {2'b00, block_in[2*r+1][2*c]}
                       + {2'b00, block_in[2*r+1][2*c+1]}
                       + 10'd2;
      assign quadAvg[r][c] = windowSum[9:2];
    end
  end

  assign isChroma = (ch == CH_CB) || (ch == CH_CR);
  // A chroma block opens a fresh group when nothing is staged or when its
  // tag disagrees with the group in progress (the partial group is dropped).
  assign startNew = isChroma && ((state_q == EMPTY) || (ch != grpCh_q));
  assign quadSel  = startNew ? 2'd0 : state_q;

  // Overlay the freshly averaged quadrant onto the staged quadrants.
  always_comb begin
    merged = staging_q;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        merged[{quadSel[1], r[1:0]}][{quadSel[0], c[1:0]}] = quadAvg[r][c];
      end
    end
  end

  // Next-state: group sequencing, staging writes and output loads.
  always_comb begin
    state_d    = state_q;
    grpCh_d    = grpCh_q;
    staging_d  = staging_q;
    blockOut_d = blockOut_q;
    chOut_d    = chOut_q;
    validOut_d = 1'b0;
    if (valid_in) begin
      case (ch)
        CH_Y: begin
          blockOut_d = block_in;
          chOut_d    = CH_Y;
          validOut_d = 1'b1;
          state_d    = EMPTY;
        end
        CH_CB, CH_CR: begin
          if (startNew) begin
            staging_d = merged;
            grpCh_d   = ch;
            state_d   = Q1;
          end else if (state_q == Q3) begin
            blockOut_d = merged;
            chOut_d    = grpCh_q;
            validOut_d = 1'b1;
            state_d    = EMPTY;
          end else begin
            staging_d = merged;
            state_d   = (state_q == Q1) ? Q2 : Q3;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      grpCh_q    <= 2'b00;
      staging_q  <= '0;
      blockOut_q <= '0;
      chOut_q    <= 2'b00;
      validOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grpCh_q    <= grpCh_d;
      staging_q  <= staging_d;
      blockOut_q <= blockOut_d;
      chOut_q    <= chOut_d;
      validOut_q <= validOut_d;
    end
  end

  assign valid_out = validOut_q;
  assign block_out = blockOut_q;
  assign ch_out    = chOut_q;

endmodule

// File: tb/tb_subsample_8x8.sv
// tb_subsample_8x8: scoreboard bench for the 4:2:0 chroma downsampler.
// Stimulus pushes the expected output (with its due cycle) when the block
// that completes a group is driven; a monitor pops on every valid_out pulse.
module tb_subsample_8x8;

  typedef logic [7:0][7:0][7:0] blk_t;
  typedef struct {
    logic [1:0] ch;
    blk_t       blk;
    int         due;
    string      name;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] ch = 2'b00;
  logic       valid_in = 1'b0;
  blk_t       block_in = '0;
  logic       valid_out;
  blk_t       block_out;
  logic [1:0] ch_out;

  int         checks = 0;
  int         failures = 0;
  int         cycleCount = 0;
  bit         resetSampled = 1'b0;
  blk_t       lastBlock = '0;
  logic [1:0] lastCh = 2'b00;
  exp_t       expQ[$];

  subsample_8x8 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ch        (ch),
    .valid_in  (valid_in),
    .block_in  (block_in),
    .valid_out (valid_out),
    .block_out (block_out),
    .ch_out    (ch_out)
  );

  always #5 clock = ~clock;

  // Cycle stamp and a record of whether the last edge was a reset edge.
  always @(posedge clock) begin
    cycleCount   <= cycleCount + 1;
    resetSampled <= ~reset_n;
  end

  // Block k of a ramp group: 8i+j+64k mod 256.
  function automatic blk_t rampBlock(input int k);
    blk_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b[i][j] = 8'((8*i + j + 64*k) % 256);
    return b;
  endfunction

  // Hand-derived result for a ramp group: each window averages to
  // 16r + 2c + 64k + 5 (window offsets 0+1+8+9 plus rounding 2, over 4).
  function automatic blk_t rampExpect();
    blk_t b;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          b[(k/2)*4 + r][(k%2)*4 + c] = 8'(16*r + 2*c + 64*k + 5);
    return b;
  endfunction

  function automatic blk_t constBlock(input logic [7:0] v);
    blk_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b[i][j] = v;
    return b;
  endfunction

  // Columns alternate 1,2 so every 2x2 window is {1,2,1,2}.
  function automatic blk_t altBlock();
    blk_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b[i][j] = (j % 2 == 1) ? 8'd2 : 8'd1;
    return b;
  endfunction

  function automatic void firstDiff(input blk_t a, input blk_t b,
                                    output int ri, output int ci);
    ri = -1;
    ci = -1;
    for (int i = 7; i >= 0; i--)
      for (int j = 7; j >= 0; j--)
        if (a[i][j] !== b[i][j]) begin
          ri = i;
          ci = j;
        end
  endfunction

  task automatic applyStimulus(input logic [1:0] c, input blk_t b,
                               input bit expectOut, input blk_t expBlk,
                               input logic [1:0] expCh, input string name);
    exp_t e;
    valid_in = 1'b1;
    ch       = c;
    block_in = b;
    if (expectOut) begin
      e.ch   = expCh;
      e.blk  = expBlk;
      e.due  = cycleCount + 1;
      e.name = name;
      expQ.push_back(e);
    end
    @(posedge clock);
    #2;
    valid_in = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    int ri, ci;
    checks++;
    if (cycleCount != e.due) begin
      failures++;
      $display("[TB] FAIL %s latency: output in cycle %0d, required %0d", e.name, cycleCount, e.due);
    end
    checks++;
    if (ch_out !== e.ch) begin
      failures++;
      $display("[TB] FAIL %s ch_out: got %b, required %b", e.name, ch_out, e.ch);
    end
    checks++;
    if (block_out !== e.blk) begin
      failures++;
      firstDiff(block_out, e.blk, ri, ci);
      $display("[TB] FAIL %s block_out[%0d][%0d]: got %0d, required %0d",
               e.name, ri, ci, block_out[ri][ci], e.blk[ri][ci]);
    end
    lastBlock = e.blk;
    lastCh    = e.ch;
  endtask

  // Monitor: reset values, scoreboard pops on pulses, hold checks otherwise.
  always @(negedge clock) begin
    int ri, ci;
    exp_t e;
    while (expQ.size() > 0 && expQ[0].due < cycleCount) begin
      e = expQ.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s missing: no valid_out by cycle %0d, required in cycle %0d",
               e.name, cycleCount, e.due);
    end
    if (resetSampled) begin
      checks++;
      if (valid_out !== 1'b0 || block_out !== '0 || ch_out !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset state: valid_out=%b ch_out=%b block_out[0][0]=%0d, required 0/00/0",
                 valid_out, ch_out, block_out[0][0]);
      end
      lastBlock = '0;
      lastCh    = 2'b00;
    end else if (valid_out === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected valid_out in cycle %0d: got ch_out=%b, required no output",
                 cycleCount, ch_out);
      end else begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end else begin
      checks++;
      if (block_out !== lastBlock || ch_out !== lastCh) begin
        failures++;
        firstDiff(block_out, lastBlock, ri, ci);
        $display("[TB] FAIL hold in cycle %0d: ch_out=%b block_out[%0d][%0d]=%0d, required ch_out=%b value %0d",
                 cycleCount, ch_out, ri, ci,
                 (ri >= 0) ? block_out[ri][ci] : 8'd0, lastCh,
                 (ri >= 0) ? lastBlock[ri][ci] : 8'd0);
      end
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: sequence did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    blk_t none;
    none = '0;

    // Reset held over a coincident Y block, which must be ignored.
    reset_n  = 1'b0;
    valid_in = 1'b1;
    ch       = 2'b00;
    block_in = constBlock(8'h55);
    repeat (2) @(posedge clock);
    #2;
    reset_n  = 1'b1;
    valid_in = 1'b0;
    idleCycles(2);

    $display("[TB] Y passthrough and hold");
    applyStimulus(2'b00, rampBlock(0), 1'b1, rampBlock(0), 2'b00, "y_ramp");
    idleCycles(3);

    $display("[TB] back-to-back Y outputs");
    applyStimulus(2'b00, constBlock(8'h3C), 1'b1, constBlock(8'h3C), 2'b00, "y_b2b_a");
    applyStimulus(2'b00, constBlock(8'hC3), 1'b1, constBlock(8'hC3), 2'b00, "y_b2b_b");
    idleCycles(2);

    $display("[TB] contiguous Cb ramp group");
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b01, rampBlock(k), k == 3, rampExpect(), 2'b01, "cb_ramp");
    idleCycles(2);

    $display("[TB] rounding and extremes");
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b10, altBlock(), k == 3, constBlock(8'd2), 2'b10, "cr_round");
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b01, constBlock(8'hFF), k == 3, constBlock(8'hFF), 2'b01, "cb_all255");
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b10, constBlock(8'h00), k == 3, constBlock(8'h00), 2'b10, "cr_all0");
    idleCycles(2);

    $display("[TB] gapped Cb ramp group");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, rampBlock(k), k == 3, rampExpect(), 2'b01, "cb_gapped");
      if (k < 3) idleCycles(3);
    end
    idleCycles(2);

    $display("[TB] abort by Y, then Cr group");
    applyStimulus(2'b01, constBlock(8'd77), 1'b0, none, 2'b00, "");
    applyStimulus(2'b01, constBlock(8'd77), 1'b0, none, 2'b00, "");
    applyStimulus(2'b00, constBlock(8'hA5), 1'b1, constBlock(8'hA5), 2'b00, "y_abort");
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b10, rampBlock(k), k == 3, rampExpect(), 2'b10, "cr_after_y");
    idleCycles(2);

    $display("[TB] abort by channel change");
    applyStimulus(2'b01, constBlock(8'd200), 1'b0, none, 2'b00, "");
    applyStimulus(2'b01, constBlock(8'd200), 1'b0, none, 2'b00, "");
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b10, rampBlock(k), k == 3, rampExpect(), 2'b10, "cr_after_cb");
    idleCycles(2);

    $display("[TB] reset mid-group");
    for (int k = 0; k < 3; k++)
      applyStimulus(2'b01, constBlock(8'd99), 1'b0, none, 2'b00, "");
    reset_n = 1'b0;
    idleCycles(1);
    reset_n = 1'b1;
    idleCycles(1);
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b01, rampBlock(k), k == 3, rampExpect(), 2'b01, "cb_after_reset");
    idleCycles(2);

    $display("[TB] illegal channel tag");
    for (int k = 0; k < 3; k++)
      applyStimulus(2'b11, constBlock(8'd11), 1'b0, none, 2'b00, "");
    idleCycles(2);
    applyStimulus(2'b01, rampBlock(0), 1'b0, none, 2'b00, "");
    applyStimulus(2'b01, rampBlock(1), 1'b0, none, 2'b00, "");
    applyStimulus(2'b11, constBlock(8'd250), 1'b0, none, 2'b00, "");
    applyStimulus(2'b01, rampBlock(2), 1'b0, none, 2'b00, "");
    applyStimulus(2'b01, rampBlock(3), 1'b1, rampExpect(), 2'b01, "cb_skip_illegal");
    idleCycles(3);

    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending outputs: got %0d outstanding, required 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
